fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end for the RISC datapath. It replaces the bare `pc` register and `pc_addr` incrementer with a fetch unit that drives a synchronous-read instruction memory, buffers fetched instructions in a small queue, and applies decode-side back-pressure and branch redirect/flush. It sits between the instruction memory and the decode/register-file stage and provides each instruction tagged with its own PC.

---
 rtl/fetch_queue_unit_pkg.sv | 14 +
 rtl/fetch_queue_unit_if.sv | 28 ++
 rtl/fetch_queue_unit_fifo.sv | 71 +++++++
 rtl/fetch_queue_unit.sv | 92 +++++++++
 tb/tb_fetch_queue_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared fetch-side definitions: default PC/width parameters and the queued
// instruction entry type.
package riscv_pkg;

  localparam int unsigned     XLEN     = 32;
  localparam int unsigned     PC_STEP  = 1;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch unit bundle: instruction-memory port, redirect input and decode-side
// handshake. master = fetch unit, slave = memory/decode environment.
interface fetch_queue_unit_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            dec_ready;
  logic [31:0]     fetch_count;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_count,
    input  imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_count,
    output imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// Power-of-two FIFO of fetched {inst, pc} entries. Same-cycle push and pop are
// allowed at any fill level; flush wins over both.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  entry_t                  push_data_i,
  input  logic                    pop_i,
  output logic                    valid_o,
  output entry_t                  head_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: issues sequential fetches to a synchronous-read
// memory, queues responses tagged with their PC, honours decode back-pressure and redirects.
module fetch_queue_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_STEP  = riscv_pkg::PC_STEP,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  fetch_queue_unit_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     fetch_count_q, fetch_count_d;

  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            head_valid, pop, push, issue;
  entry_t          head, push_data;

  // Credit check counts the response still in flight so the queue never overflows.
  assign pop       = head_valid & bus.dec_ready;
  assign push      = inflight_q & ~bus.redirect_valid;
  assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue     = ~reset & ~bus.redirect_valid & (occupancy < (CW+1)'(DEPTH));

  assign push_data.inst = bus.imem_rdata;
  assign push_data.pc   = inflight_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    fetch_count_d = fetch_count_q + 32'(pop);
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + XLEN'(PC_STEP);
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fetch_count_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (bus.redirect_valid),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .valid_o     (head_valid),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.inst_valid  = head_valid;
  assign bus.inst        = head.inst;
  assign bus.inst_pc     = head.pc;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: vector table for startup/back-pressure timing,
// hand sequences for redirect/reset corners, and a request-order scoreboard.
module tb_fetch_queue_unit;
  import riscv_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  fetch_queue_unit_if #(.XLEN(XLEN)) bus ();

  fetch_queue_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .PC_STEP  (1),
    .RESET_PC ('0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: 0xA000_0000 | addr one cycle later.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= 32'hA000_0000 | bus.imem_addr;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] req_q[$];
  logic [31:0] exp_addr;
  logic [31:0] hs_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Scoreboard: every issued address is expected back at decode in order,
  // unless a redirect or reset discards everything outstanding.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        req_q.delete();
        exp_addr = '0;
        hs_cnt   = '0;
      end else begin
        if (bus.inst_valid && bus.dec_ready) begin
          hs_cnt = hs_cnt + 32'd1;
          if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_inst: got pc %h required no valid entry", bus.inst_pc);
          end else begin
            logic [31:0] e;
            e = req_q.pop_front();
            chk("sb_inst_pc", bus.inst_pc, e);
            chk("sb_inst", bus.inst, 32'hA000_0000 | e);
          end
        end
        if (bus.imem_req) begin
          chk("sb_imem_addr", bus.imem_addr, exp_addr);
          req_q.push_back(bus.imem_addr);
          exp_addr = bus.imem_addr + 32'd1;
        end
        if (bus.redirect_valid) begin
          chk("sb_no_req_on_redirect", {31'd0, bus.imem_req}, 32'd0);
          req_q.delete();
          exp_addr = bus.redirect_pc;
        end
      end
    end
  end

  typedef struct {
    bit          rst_before;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("watchdog expired before the bench completed");
    $fatal(1, "timeout");
  end

  initial begin
    reset              = 1'b1;
    bus.dec_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Startup with decode always ready: one instruction per cycle from cycle 2.
    tbl[0]  = '{1, 1, 1, 32'd0, 0, 32'd0};
    tbl[1]  = '{0, 1, 1, 32'd1, 0, 32'd0};
    tbl[2]  = '{0, 1, 1, 32'd2, 1, 32'd0};
    tbl[3]  = '{0, 1, 1, 32'd3, 1, 32'd1};
    tbl[4]  = '{0, 1, 1, 32'd4, 1, 32'd2};
    tbl[5]  = '{0, 1, 1, 32'd5, 1, 32'd3};
    // Back-pressure from cycle 3: queue fills, request stops, head holds; then release.
    tbl[6]  = '{1, 1, 1, 32'd0, 0, 32'd0};
    tbl[7]  = '{0, 1, 1, 32'd1, 0, 32'd0};
    tbl[8]  = '{0, 1, 1, 32'd2, 1, 32'd0};
    tbl[9]  = '{0, 0, 1, 32'd3, 1, 32'd1};
    tbl[10] = '{0, 0, 1, 32'd4, 1, 32'd1};
    tbl[11] = '{0, 0, 0, 32'd0, 1, 32'd1};
    tbl[12] = '{0, 0, 0, 32'd0, 1, 32'd1};
    tbl[13] = '{0, 0, 0, 32'd0, 1, 32'd1};
    tbl[14] = '{0, 1, 1, 32'd5, 1, 32'd1};
    tbl[15] = '{0, 1, 1, 32'd6, 1, 32'd2};
    tbl[16] = '{0, 1, 1, 32'd7, 1, 32'd3};
    tbl[17] = '{0, 1, 1, 32'd8, 1, 32'd4};

    #12;
    chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'd0);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_fetch_count", bus.fetch_count, 32'd0);

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rst_before) do_reset();
      bus.dec_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), {31'd0, bus.imem_req}, {31'd0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("vec%0d_addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.inst_valid}, {31'd0, tbl[i].vld});
      if (tbl[i].vld) begin
        chk($sformatf("vec%0d_pc", i), bus.inst_pc, tbl[i].pc);
        chk($sformatf("vec%0d_inst", i), bus.inst, 32'hA000_0000 | tbl[i].pc);
      end
      cyc();
    end

    // Redirect to 0x40 while full, with a pop in the same cycle.
    do_reset();
    bus.dec_ready = 1'b0;
    repeat (6) cyc();
    @(negedge clk);
    chk("full_req_stopped", {31'd0, bus.imem_req}, 32'd0);
    chk("full_head_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("full_head_pc", bus.inst_pc, 32'd0);
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    bus.dec_ready      = 1'b1;
    @(negedge clk);
    chk("redir_no_req", {31'd0, bus.imem_req}, 32'd0);
    cyc();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_t1_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("redir_t1_req", {31'd0, bus.imem_req}, 32'd1);
    chk("redir_t1_addr", bus.imem_addr, 32'h40);
    cyc();
    @(negedge clk);
    chk("redir_t2_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("redir_t2_addr", bus.imem_addr, 32'h41);
    cyc();
    @(negedge clk);
    chk("redir_t3_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("redir_t3_pc", bus.inst_pc, 32'h40);
    chk("redir_t3_inst", bus.inst, 32'hA000_0040);
    repeat (4) cyc();

    // Redirect in the cycle the response for address 0 returns.
    do_reset();
    bus.dec_ready = 1'b1;
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    cyc();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("resp_redir_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("resp_redir_addr", bus.imem_addr, 32'h80);
    cyc();
    @(negedge clk);
    chk("resp_redir_valid2", {31'd0, bus.inst_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("resp_redir_first_pc", bus.inst_pc, 32'h80);
    chk("resp_redir_first_valid", {31'd0, bus.inst_valid}, 32'd1);
    repeat (4) cyc();

    // Asynchronous reset asserted between clock edges mid-stream.
    #2;
    reset = 1'b1;
    #1;
    chk("async_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("async_imem_addr", bus.imem_addr, 32'd0);
    chk("async_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("async_inst", bus.inst, 32'd0);
    chk("async_inst_pc", bus.inst_pc, 32'd0);
    chk("async_fetch_count", bus.fetch_count, 32'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("async_restart_req", {31'd0, bus.imem_req}, 32'd1);
    chk("async_restart_addr", bus.imem_addr, 32'd0);
    cyc();
    #1;
    chk("async_restart_count", bus.fetch_count, 32'd0);

    // Random decode back-pressure with occasional redirects; count handshakes.
    for (int i = 0; i < 100; i++) begin
      bus.dec_ready      = 1'($urandom_range(0, 1));
      bus.redirect_valid = ($urandom_range(0, 15) == 0);
      bus.redirect_pc    = 32'($urandom_range(0, 255));
      cyc();
      if (i % 25 == 24) begin
        #1;
        chk("rand_fetch_count", bus.fetch_count, hs_cnt);
      end
    end

    // Wrap of fetch_count at 2^32.
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b0;
    repeat (6) cyc();
    #1;
    dut.fetch_count_q = 32'hFFFF_FFFF;
    hs_cnt            = 32'hFFFF_FFFF;
    #1;
    chk("preload_count", bus.fetch_count, 32'hFFFF_FFFF);
    cyc();
    bus.dec_ready = 1'b1;
    @(negedge clk);
    chk("wrap_pop_valid", {31'd0, bus.inst_valid}, 32'd1);
    cyc();
    bus.dec_ready = 1'b0;
    #1;
    chk("wrap_count_zero", bus.fetch_count, 32'd0);
    chk("wrap_count_model", bus.fetch_count, hs_cnt);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
